mw_pipe_reg: RTL and testbench
==============================

// Module: mw_pipe_reg
// PURPOSE
//  M/W pipeline stage register plus writeback data path. Captures memory-stage results each
//  clk, sign/zero-extends load data, selects the writeback value and drives the register
//  file write port (W_RegWrite, W_A3, W_DMout). It sits directly upstream of the register file.
// PARAMETERS
//  LINK_OFFSET  8             byte offset added to PC for link writeback (jal/jalr)
//  RESET_PC     32'h0000_3000 value of W_PC after reset/flush
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  reset        in   1   asynchronous, active-high; clears all stage state
//  stall        in   1   hold W-stage contents this cycle
//  flush        in   1   load a bubble (no write) at next posedge
//  M_PC         in   32  PC of instruction in M
//  M_RegWrite   in   1   instruction in M writes a register
//  M_A3         in   5   destination register of instruction in M
//  M_WBSel      in   2   00 ALU result, 01 load data, 10 PC+LINK_OFFSET, 11 ALU result
//  M_ALUout     in   32  ALU/E-stage result carried through M
//  M_DMrd       in   32  raw aligned word read from data memory
//  M_LoadOp     in   3   000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh, others treated as lw
//  M_Addr       in   2   byte offset (address[1:0]) of the load
//  W_PC         out  32  PC of instruction in W
//  W_RegWrite   out  1   register write enable to register file
//  W_A3         out  5   write address to register file
//  W_DMout      out  32  final writeback data to register file
// BEHAVIOUR
//  - Registered fields: PC, RegWrite, A3, WBSel, ALUout, DMrd, LoadOp, Addr.
//  - Priority at each posedge: reset (async) > flush > stall > capture.
//  - reset asserted (any time, independent of clk): PC=RESET_PC, all other fields 0;
//    outputs immediately read W_PC=RESET_PC, W_RegWrite=0, W_A3=0, W_DMout=0.
//  - flush: same values as reset, loaded synchronously; stall ignored when flush is high.
//  - stall (flush low): every field holds; outputs unchanged.
//  - capture: fields take M_* values; latency exactly 1 cycle M->W.
//  - W_RegWrite = reg RegWrite & (reg A3 != 0); a write to $0 never reaches the register
//    file or any forwarding path.
//  - W_A3 = reg A3 regardless of RegWrite.
//  - Load extension (combinational from registered DMrd/Addr/LoadOp):
//      byte  = DMrd[8*Addr +: 8]; lbu zero-extends, lb sign-extends bit 7.
//      half  = Addr[1] ? DMrd[31:16] : DMrd[15:0]; Addr[0] ignored; lhu zero-, lh sign-ext.
//      lw / undefined LoadOp: full word, Addr ignored.
//  - W_DMout: WBSel 01 -> extended load data; 10 -> PC + LINK_OFFSET (32-bit, wraps modulo
//    2^32); 00/11 -> ALUout.
//  - W_DMout is valid in the same cycle the fields are registered, so the register file
//    writes it at the following posedge and can bypass it combinationally to D-stage reads.
//  - No handshake; the block always accepts when stall is low.
//  - Reset deasserted mid-cycle: first capture happens at the next posedge.
// TESTING
//  1 reset high, M_RegWrite=1 M_A3=5 -> W_RegWrite=0 W_A3=0 W_DMout=0 W_PC=0x3000; release,
//    one edge -> W_A3=5 W_RegWrite=1 with the data that was on the inputs at that edge.
//  2 lb M_DMrd=0x80FF7F01: Addr=0 -> 0x00000001, Addr=1 -> 0x0000007F, Addr=2 -> 0xFFFFFFFF,
//    Addr=3 -> 0xFFFFFF80; lbu Addr=3 -> 0x00000080; lh Addr=2 -> 0xFFFF80FF,
//    lhu Addr=3 -> 0x000080FF.
//  3 WBSel=10 M_PC=0x00003010 -> W_DMout=0x00003018; M_PC=0xFFFFFFFC -> 0x00000004.
//  4 M_RegWrite=1 M_A3=0 ALUout=0x1234 -> W_RegWrite=0, W_A3=0, W_DMout=0x1234.
//  5 capture A3=7 data 0xAA, then stall=1 for 3 cycles while inputs change -> W outputs stay
//    A3=7/0xAA; stall=1 flush=1 together -> bubble (W_RegWrite=0, W_PC=0x3000) next edge.
//  6 assert reset between edges with W_RegWrite=1 -> W_RegWrite falls immediately,
//    without waiting for a clk edge.

Source files
------------

// File: rtl/mw_pipe_reg.sv
// ---------------------------------------------------------------------------
// mw_pipe_reg
//   M/W pipeline stage register and writeback data path. It captures the
//   memory-stage results on every clk edge, extends the loaded data and
//   selects the writeback value. The outputs drive the register file write
//   port directly.
//
// Parameters
//   LINK_OFFSET  byte offset added to the PC for a link writeback (jal/jalr)
//   RESET_PC     W_PC value after reset or flush
//
// Ports
//   clk          clock; all state updates happen on posedge
//   reset        asynchronous, active-high; clears all stage state
//   stall        holds the W-stage contents this cycle
//   flush        loads a bubble (no register write) at the next posedge
//   M_PC         PC of the instruction in M
//   M_RegWrite   the instruction in M writes a register
//   M_A3         destination register of the instruction in M
//   M_WBSel      00 ALU, 01 load data, 10 PC+LINK_OFFSET, 11 ALU
//   M_ALUout     ALU/E-stage result carried through M
//   M_DMrd       raw aligned word read from data memory
//   M_LoadOp     000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh, others as lw
//   M_Addr       byte offset of the load (address[1:0])
//   W_PC         PC of the instruction in W
//   W_RegWrite   register file write enable (never asserted for $0)
//   W_A3         register file write address
//   W_DMout      final writeback data
// ---------------------------------------------------------------------------
module mw_pipe_reg #(
  parameter logic [31:0] LINK_OFFSET = 32'd8,
  parameter logic [31:0] RESET_PC    = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] M_PC,
  input  logic        M_RegWrite,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  M_WBSel,
  input  logic [31:0] M_ALUout,
  input  logic [31:0] M_DMrd,
  input  logic [2:0]  M_LoadOp,
  input  logic [1:0]  M_Addr,
  output logic [31:0] W_PC,
  output logic        W_RegWrite,
  output logic [4:0]  W_A3,
  output logic [31:0] W_DMout
);

  // Load operation encodings
  localparam logic [2:0] LOAD_LW  = 3'b000;
  localparam logic [2:0] LOAD_LBU = 3'b001;
  localparam logic [2:0] LOAD_LB  = 3'b010;
  localparam logic [2:0] LOAD_LHU = 3'b011;
  localparam logic [2:0] LOAD_LH  = 3'b100;

  // Writeback source encodings
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  // ------------------------------------------------------------------------
  // Stage registers
  // ------------------------------------------------------------------------
  logic [31:0] r_pc;
  logic        r_regwrite;
  logic [4:0]  r_a3;
  logic [1:0]  r_wbsel;
  logic [31:0] r_aluout;
  logic [31:0] r_dmrd;
  logic [2:0]  r_loadop;
  logic [1:0]  r_addr;

  // flush takes priority over stall, so a held instruction can still be
  // squashed. A flush loads exactly the reset image.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_regwrite <= 1'b0;
      r_a3       <= '0;
      r_wbsel    <= '0;
      r_aluout   <= '0;
      r_dmrd     <= '0;
      r_loadop   <= '0;
      r_addr     <= '0;
    end else if (flush) begin
      r_pc       <= RESET_PC;
      r_regwrite <= 1'b0;
      r_a3       <= '0;
      r_wbsel    <= '0;
      r_aluout   <= '0;
      r_dmrd     <= '0;
      r_loadop   <= '0;
      r_addr     <= '0;
    end else if (!stall) begin
      r_pc       <= M_PC;
      r_regwrite <= M_RegWrite;
      r_a3       <= M_A3;
      r_wbsel    <= M_WBSel;
      r_aluout   <= M_ALUout;
      r_dmrd     <= M_DMrd;
      r_loadop   <= M_LoadOp;
      r_addr     <= M_Addr;
    end
  end

  // ------------------------------------------------------------------------
  // Load extension
  // ------------------------------------------------------------------------
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  always_comb begin
    w_byte = r_dmrd[7:0];
    unique case (r_addr)
      2'd0: w_byte = r_dmrd[7:0];
      2'd1: w_byte = r_dmrd[15:8];
      2'd2: w_byte = r_dmrd[23:16];
      2'd3: w_byte = r_dmrd[31:24];
    endcase
  end

  // Halfword selection uses only Addr[1]; a misaligned Addr[0] is ignored.
  assign w_half = r_addr[1] ? r_dmrd[31:16] : r_dmrd[15:0];

  always_comb begin
    w_load = r_dmrd;
    case (r_loadop)
      LOAD_LBU: w_load = {24'd0, w_byte};
      LOAD_LB:  w_load = {{24{w_byte[7]}}, w_byte};
      LOAD_LHU: w_load = {16'd0, w_half};
      LOAD_LH:  w_load = {{16{w_half[15]}}, w_half};
      LOAD_LW:  w_load = r_dmrd;
      default:  w_load = r_dmrd;
    endcase
  end

  // ------------------------------------------------------------------------
  // Writeback selection
  // ------------------------------------------------------------------------
  logic [31:0] w_link;
  logic [31:0] w_wbdata;

  // 32-bit add; the link address wraps around the top of the address space.
  assign w_link = r_pc + LINK_OFFSET;

  always_comb begin
    w_wbdata = r_aluout;
    case (r_wbsel)
      WB_LOAD: w_wbdata = w_load;
      WB_LINK: w_wbdata = w_link;
      WB_ALU:  w_wbdata = r_aluout;
      default: w_wbdata = r_aluout;
    endcase
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  // Writes to $0 are suppressed here so that neither the register file nor
  // any forwarding path downstream ever sees one.
  assign W_RegWrite = r_regwrite & (r_a3 != 5'd0);
  assign W_A3       = r_a3;
  assign W_PC       = r_pc;
  assign W_DMout    = w_wbdata;

endmodule

// File: tb/tb_mw_pipe_reg.sv
module tb_mw_pipe_reg;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] M_PC;
  logic        M_RegWrite;
  logic [4:0]  M_A3;
  logic [1:0]  M_WBSel;
  logic [31:0] M_ALUout;
  logic [31:0] M_DMrd;
  logic [2:0]  M_LoadOp;
  logic [1:0]  M_Addr;
  logic [31:0] W_PC;
  logic        W_RegWrite;
  logic [4:0]  W_A3;
  logic [31:0] W_DMout;

  int n_cmp = 0;
  int n_bad = 0;

  mw_pipe_reg #(
    .LINK_OFFSET(32'd8),
    .RESET_PC   (32'h0000_3000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .M_PC      (M_PC),
    .M_RegWrite(M_RegWrite),
    .M_A3      (M_A3),
    .M_WBSel   (M_WBSel),
    .M_ALUout  (M_ALUout),
    .M_DMrd    (M_DMrd),
    .M_LoadOp  (M_LoadOp),
    .M_Addr    (M_Addr),
    .W_PC      (W_PC),
    .W_RegWrite(W_RegWrite),
    .W_A3      (W_A3),
    .W_DMout   (W_DMout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: the instruction currently held in W
  // ---------------------------------------------------------------------
  logic [31:0] m_pc  = 32'h0000_3000;
  logic        m_rw  = 1'b0;
  logic [4:0]  m_a3  = 5'd0;
  logic [1:0]  m_wb  = 2'd0;
  logic [31:0] m_alu = 32'd0;
  logic [31:0] m_dm  = 32'd0;
  logic [2:0]  m_op  = 3'd0;
  logic [1:0]  m_ad  = 2'd0;

  always @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      m_pc <= 32'h0000_3000; m_rw <= 1'b0; m_a3 <= 5'd0; m_wb <= 2'd0;
      m_alu <= 32'd0; m_dm <= 32'd0; m_op <= 3'd0; m_ad <= 2'd0;
    end else if (!stall) begin
      m_pc <= M_PC; m_rw <= M_RegWrite; m_a3 <= M_A3; m_wb <= M_WBSel;
      m_alu <= M_ALUout; m_dm <= M_DMrd; m_op <= M_LoadOp; m_ad <= M_Addr;
    end
  end

  function automatic logic [31:0] load_val(input logic [31:0] d, input logic [1:0] a,
                                           input logic [2:0] op);
    logic [31:0] b;
    logic [31:0] h;
    int unsigned sh;
    sh = 8 * a;
    b  = (d >> sh) & 32'h0000_00FF;
    sh = 16 * a[1];
    h  = (d >> sh) & 32'h0000_FFFF;
    case (op)
      3'd1:    return b;
      3'd2:    return (b >= 32'd128) ? (b - 32'd256) : b;
      3'd3:    return h;
      3'd4:    return (h >= 32'd32768) ? (h - 32'd65536) : h;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_dmout();
    if (m_wb == 2'd1) return load_val(m_dm, m_ad, m_op);
    if (m_wb == 2'd2) return m_pc + 32'd8;
    return m_alu;
  endfunction

  // Compare process: checks every cycle, 1 time unit after the edge
  always begin
    @(posedge clk);
    #1;
    chk("pc",       W_PC,                {27'd0, 5'd0} | m_pc);
    chk("regwrite", {31'd0, W_RegWrite}, {31'd0, (m_rw && m_a3 != 5'd0)});
    chk("a3",       {27'd0, W_A3},       {27'd0, m_a3});
    chk("dmout",    W_DMout,             exp_dmout());
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [31:0] pc, input logic rw, input logic [4:0] a3,
                        input logic [1:0] wb, input logic [31:0] alu, input logic [31:0] dm,
                        input logic [2:0] op, input logic [1:0] ad);
    M_PC = pc; M_RegWrite = rw; M_A3 = a3; M_WBSel = wb;
    M_ALUout = alu; M_DMrd = dm; M_LoadOp = op; M_Addr = ad;
  endtask

  task automatic rand_in();
    set_in($urandom, 1'($urandom), 5'($urandom), 2'($urandom), $urandom, $urandom,
           3'($urandom_range(0, 7)), 2'($urandom));
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  ad;
    logic [31:0] exp;
  } load_case_t;

  load_case_t lc[7];

  initial begin
    lc[0] = '{3'd2, 2'd0, 32'h0000_0001};
    lc[1] = '{3'd2, 2'd1, 32'h0000_007F};
    lc[2] = '{3'd2, 2'd2, 32'hFFFF_FFFF};
    lc[3] = '{3'd2, 2'd3, 32'hFFFF_FF80};
    lc[4] = '{3'd1, 2'd3, 32'h0000_0080};
    lc[5] = '{3'd4, 2'd2, 32'hFFFF_80FF};
    lc[6] = '{3'd3, 2'd3, 32'h0000_80FF};

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_in(32'h0000_1000, 1'b1, 5'd5, 2'd0, 32'h0000_0055, 32'd0, 3'd0, 2'd0);

    // 1: reset state visible before any clock edge, and held across edges
    #3;
    chk("rst_pc",  W_PC, 32'h0000_3000);
    chk("rst_rw",  {31'd0, W_RegWrite}, 32'd0);
    chk("rst_a3",  {27'd0, W_A3}, 32'd0);
    chk("rst_dm",  W_DMout, 32'd0);
    tick();
    tick();
    chk("rst_hold_a3", {27'd0, W_A3}, 32'd0);
    reset = 1'b0;
    tick();
    chk("rel_a3", {27'd0, W_A3}, 32'd5);
    chk("rel_rw", {31'd0, W_RegWrite}, 32'd1);
    chk("rel_dm", W_DMout, 32'h0000_0055);
    chk("rel_pc", W_PC, 32'h0000_1000);

    // 2: load extension
    foreach (lc[i]) begin
      set_in(32'h0000_2000, 1'b1, 5'd3, 2'd1, 32'hDEAD_BEEF, 32'h80FF_7F01, lc[i].op, lc[i].ad);
      tick();
      chk($sformatf("load%0d", i), W_DMout, lc[i].exp);
    end

    // 3: link writeback, including wrap
    set_in(32'h0000_3010, 1'b1, 5'd31, 2'd2, 32'd0, 32'd0, 3'd0, 2'd0);
    tick();
    chk("link", W_DMout, 32'h0000_3018);
    M_PC = 32'hFFFF_FFFC;
    tick();
    chk("link_wrap", W_DMout, 32'h0000_0004);

    // 4: write to $0 suppressed
    set_in(32'h0000_3020, 1'b1, 5'd0, 2'd0, 32'h0000_1234, 32'd0, 3'd0, 2'd0);
    tick();
    chk("r0_rw", {31'd0, W_RegWrite}, 32'd0);
    chk("r0_a3", {27'd0, W_A3}, 32'd0);
    chk("r0_dm", W_DMout, 32'h0000_1234);

    // 5: stall holds, flush overrides stall
    set_in(32'h0000_3024, 1'b1, 5'd7, 2'd0, 32'h0000_00AA, 32'd0, 3'd0, 2'd0);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      tick();
      chk("stall_a3", {27'd0, W_A3}, 32'd7);
      chk("stall_dm", W_DMout, 32'h0000_00AA);
    end
    flush = 1'b1;
    tick();
    chk("flush_rw", {31'd0, W_RegWrite}, 32'd0);
    chk("flush_pc", W_PC, 32'h0000_3000);
    stall = 1'b0; flush = 1'b0;

    // 6: asynchronous reset between edges
    set_in(32'h0000_4000, 1'b1, 5'd9, 2'd0, 32'h0000_0099, 32'd0, 3'd0, 2'd0);
    tick();
    chk("pre_arst_rw", {31'd0, W_RegWrite}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_rw", {31'd0, W_RegWrite}, 32'd0);
    chk("arst_pc", W_PC, 32'h0000_3000);
    reset = 1'b0;
    tick();
    chk("post_arst_a3", {27'd0, W_A3}, 32'd9);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rand_in();
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 2) begin
        reset = 1'b1;
        #1 reset = 1'b0;
      end
      tick();
    end

    stall = 1'b0; flush = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
